fetch_sequencer: RTL

- Owns the fetch PC of the pipelined MIPS core and sequences instruction fetch into the IF stage and the instruction memory.
- Selects the next PC from sequential +4 or a D-stage branch/jump redirect (delay-slot architecture, no flush).
- Freezes fetch on load-use hazards and while the multi-cycle mult/div unit is busy and a dependent instruction sits in D.
- Detects illegal fetch targets and parks the core in a sticky fault state.

---
 rtl/fetch_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC sequencer with stall, redirect, mult/div busy and fault tracking
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          IM_WORDS    = 1024,
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10,
    parameter int          CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        stall_d,
    output logic        md_busy,
    output logic        pc_fault
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // One past the last legal fetch address; 33 bits so the bound cannot wrap.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] cand_pc;
    logic        cand_illegal;
    logic        running;

    assign running  = (state_q == ST_RUN);
    assign pc       = pc_q;
    assign if_valid = running;
    assign pc_fault = (state_q == ST_FAULT);
    assign md_busy  = (cnt_q != '0);
    assign stall_d  = running & (hazard_stall | (md_busy & md_use));

    // Candidate next fetch address and its legality against the memory window.
    always_comb begin
        cand_pc      = redirect ? redirect_pc : (pc_q + 32'd4);
        cand_illegal = (cand_pc[1:0] != 2'b00)
                     | (cand_pc < RESET_PC)
                     | ({1'b0, cand_pc} >= PC_LIMIT);
    end

    // Sequencing: BOOT lasts one cycle, RUN accepts unstalled candidates, FAULT is terminal.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!stall_d) begin
                    if (cand_illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = cand_pc;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Mult/div busy counter: a start (re)loads, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
